// File: rtl/bist_engine.sv
// BIST engine for the adder path: LFSR-driven pattern register feeds two operands
// to the CUT, a Galois MISR compacts returned results, verdict compares to a golden signature.
module bist_engine #(
    parameter int                    ADD_BIT   = 16,
    parameter int                    LFSR_LEN  = 7,
    parameter logic [LFSR_LEN-1:0]   LFSR_TAPS = 7'b1100000,
    parameter logic [LFSR_LEN-1:0]   LFSR_SEED = 7'b0000001,
    parameter logic [ADD_BIT:0]      MISR_TAPS = 17'h10009,
    parameter int                    CNT_W     = 16,
    parameter int                    TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_pat,
    input  logic [ADD_BIT:0]   golden,
    output logic               cut_valid,
    output logic [ADD_BIT-1:0] cut_a,
    output logic [ADD_BIT-1:0] cut_b,
    input  logic               cut_res_valid,
    input  logic [ADD_BIT:0]   cut_res,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout_err,
    output logic [ADD_BIT:0]   signature
);

    localparam int W      = ADD_BIT + 1;
    localparam int SR_W   = 2 * ADD_BIT;
    localparam int WARM_W = $clog2(SR_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
        return {s[LFSR_LEN-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [W-1:0] misr_step(input logic [W-1:0] m, input logic [W-1:0] r);
        return ({m[W-2:0], 1'b0} ^ (m[W-1] ? MISR_TAPS : '0)) ^ r;
    endfunction

    state_t             state_q,    state_d;
    logic [LFSR_LEN-1:0] lfsr_q,    lfsr_d;
    logic [SR_W-1:0]    sr_q,       sr_d;
    logic [W-1:0]       misr_q,     misr_d;
    logic [CNT_W-1:0]   pat_cnt_q,  pat_cnt_d;
    logic [CNT_W-1:0]   res_cnt_q,  res_cnt_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   num_pat_q,  num_pat_d;
    logic [W-1:0]       golden_q,   golden_d;
    logic               timeout_q,  timeout_d;
    logic               pass_q,     pass_d;
    logic               accept;
    logic               shift_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            sr_q       <= '0;
            misr_q     <= '0;
            pat_cnt_q  <= '0;
            res_cnt_q  <= '0;
            warm_cnt_q <= '0;
            idle_cnt_q <= '0;
            num_pat_q  <= '0;
            golden_q   <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            sr_q       <= sr_d;
            misr_q     <= misr_d;
            pat_cnt_q  <= pat_cnt_d;
            res_cnt_q  <= res_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            num_pat_q  <= num_pat_d;
            golden_q   <= golden_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        sr_d       = sr_q;
        misr_d     = misr_q;
        pat_cnt_d  = pat_cnt_q;
        res_cnt_d  = res_cnt_q;
        warm_cnt_d = warm_cnt_q;
        idle_cnt_d = idle_cnt_q;
        num_pat_d  = num_pat_q;
        golden_d   = golden_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;

        shift_en = (state_q == S_WARM) || (state_q == S_RUN);
        // Strobes past the expected count, or outside RUN/DRAIN, never touch the MISR.
        accept   = cut_res_valid && ((state_q == S_RUN) || (state_q == S_DRAIN))
                   && (res_cnt_q < num_pat_q);

        if (shift_en) begin
            lfsr_d = lfsr_step(lfsr_q);
            sr_d   = {sr_q[SR_W-2:0], lfsr_q[0]};
        end

        if (accept) begin
            misr_d    = misr_step(misr_q, cut_res);
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_WARM;
                    lfsr_d     = LFSR_SEED;
                    sr_d       = '0;
                    misr_d     = '0;
                    pat_cnt_d  = '0;
                    res_cnt_d  = '0;
                    warm_cnt_d = '0;
                    idle_cnt_d = '0;
                    num_pat_d  = num_pat;
                    golden_d   = golden;
                    timeout_d  = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            S_WARM: begin
                warm_cnt_d = warm_cnt_q + WARM_W'(1);
                if (warm_cnt_q == WARM_W'(SR_W - 1)) begin
                    state_d = (num_pat_q == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                pat_cnt_d = pat_cnt_q + CNT_W'(1);
                if (pat_cnt_q == num_pat_q - CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_cnt_q == num_pat_q) begin
                    state_d = S_DONE;
                    pass_d  = (misr_q == golden_q);
                end else if (accept) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    // A stalled CUT ends the run with a forced fail.
                    if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cut_valid   = (state_q == S_RUN);
    assign busy        = (state_q == S_WARM) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign timeout_err = timeout_q;
    assign cut_a       = sr_q[ADD_BIT-1:0];
    assign cut_b       = sr_q[SR_W-1:ADD_BIT];
    assign signature   = misr_q;

endmodule
